// File: rtl/bcp_pkg.sv
// bcp_pkg: shared BCP literal types, array sizes and literal helpers.
package bcp_pkg;
    localparam int LIT_INDEX_MAX = 1024;
    localparam int CLA_LENGTH = 8;
    localparam int NUM_PE = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int LIT_W = $clog2(LIT_INDEX_MAX) + 1;
    typedef logic signed [LIT_W-1:0] lit_t;
    typedef struct packed {
        logic assigned;
        logic polarity;
    } var_state_t;
    function automatic logic [LIT_W-2:0] lit_abs(lit_t l);
        return (LIT_W-1)'(l[LIT_W-1] ? -l : l);
    endfunction
endpackage

// File: rtl/bcp_imply_queue_if.sv
// bcp_imply_queue_if: decision, PE implication and broadcast handshakes of the implication queue.
interface bcp_imply_queue_if;
    import bcp_pkg::*;
    logic dec_valid;
    lit_t dec_lit;
    logic dec_ready;
    logic [NUM_PE-1:0] imp_valid;
    lit_t imp_lit [NUM_PE];
    logic [NUM_PE-1:0] imp_ready;
    logic [NUM_PE-1:0] pe_conflict;
    logic lit_valid;
    lit_t lit_out;
    logic lit_ready;
    logic clear;
    logic conflict;
    logic quiescent;
    modport master (
        output dec_valid, dec_lit, imp_valid, imp_lit, pe_conflict, lit_ready, clear,
        input  dec_ready, imp_ready, lit_valid, lit_out, conflict, quiescent
    );
    modport slave (
        input  dec_valid, dec_lit, imp_valid, imp_lit, pe_conflict, lit_ready, clear,
        output dec_ready, imp_ready, lit_valid, lit_out, conflict, quiescent
    );
endinterface

// File: rtl/bcp_lit_fifo.sv
// bcp_lit_fifo: synchronous literal FIFO with flush; head reads as zero when empty.
module bcp_lit_fifo
    import bcp_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  lit_t din,
    output lit_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    lit_t mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = empty ? '0 : mem[rd];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
        end else if (flush) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/bcp_imply_queue.sv
// bcp_imply_queue: arbitrates decisions/PE implications into a literal FIFO rebroadcast to the PEs.
// Define BCP_IMPLY_DEDUP_EN to add the per-variable assignment table (duplicate drop, contradiction detect).
module bcp_imply_queue
    import bcp_pkg::*;
(
    input logic clk,
    input logic rst_n,
    bcp_imply_queue_if.slave bus
);
    localparam int PW = $clog2(NUM_PE);
    typedef enum logic {RUN, CONFLICT} state_t;
    state_t st;
    logic [PW-1:0] ptr, gidx, cand;
    logic [NUM_PE-1:0] gnt;
    logic ok, dec_acc, imp_acc, acc, hit_bad, push, contra, to_conf, full, empty;
    lit_t acc_lit;
    // Scan from the pointer downwards so the PE closest after the pointer wins.
    always_comb begin
        gidx = '0;
        cand = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            cand = ptr + PW'(k);
            gidx = bus.imp_valid[cand] ? cand : gidx;
        end
        gnt = bus.imp_valid[gidx] ? NUM_PE'(1) << gidx : '0;
    end
    assign ok = rst_n && st == RUN && !full;
    assign bus.dec_ready = ok;
    assign bus.imp_ready = (ok && !bus.dec_valid) ? gnt : '0;
    assign dec_acc = bus.dec_valid && ok;
    assign imp_acc = |bus.imp_ready;
    assign acc = dec_acc || imp_acc;
    assign acc_lit = dec_acc ? bus.dec_lit : bus.imp_lit[gidx];
    // Zero and the most negative code both have an all-zero magnitude field.
    assign hit_bad = acc_lit[LIT_W-2:0] == '0;
`ifdef BCP_IMPLY_DEDUP_EN
    var_state_t tbl [LIT_INDEX_MAX];
    var_state_t ent;
    assign ent = tbl[lit_abs(acc_lit)];
    assign push = acc && !hit_bad && !ent.assigned;
    assign contra = acc && !hit_bad && ent.assigned && ent.polarity != acc_lit[LIT_W-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < LIT_INDEX_MAX; i++) tbl[i] <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < LIT_INDEX_MAX; i++) tbl[i] <= '0;
        end else if (push) begin
            tbl[lit_abs(acc_lit)] <= '{assigned: 1'b1, polarity: acc_lit[LIT_W-1]};
        end
`else
    assign push = acc && !hit_bad;
    assign contra = 1'b0;
`endif
    assign to_conf = st == RUN && (|bus.pe_conflict || contra);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st <= RUN;
            ptr <= '0;
        end else if (bus.clear) begin
            st <= RUN;
            ptr <= '0;
        end else begin
            if (to_conf) st <= CONFLICT;
            if (imp_acc) ptr <= gidx + 1'b1;
        end
    assign bus.conflict = st == CONFLICT;
    assign bus.lit_valid = st == RUN && !empty;
    assign bus.quiescent = empty && !bus.dec_valid && !(|bus.imp_valid) && st != CONFLICT;
    bcp_lit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(bus.clear || st == CONFLICT || to_conf),
        .push (push),
        .pop  (bus.lit_valid && bus.lit_ready),
        .din  (acc_lit),
        .dout (bus.lit_out),
        .full (full),
        .empty(empty)
    );
endmodule

// File: tb/tb_bcp_imply_queue.sv
// tb_bcp_imply_queue: directed vectors plus a queue/array reference model checked every cycle.
module tb_bcp_imply_queue;
    import bcp_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vec = 0;
    int bad = 0;
    bcp_imply_queue_if bus();
    bcp_imply_queue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reference model: literal queue, signed assignment per variable (+1/-1/0), conflict flag, RR start.
    int q[$];
    int asg [LIT_INDEX_MAX];
    bit m_conf = 0;
    int m_ptr = 0;
    always @(negedge clk) begin
        int idx, l, e_ir, v, s;
        bit ok, run0, acc;
        run0 = !m_conf;
        ok = rst_n && run0 && q.size() < FIFO_DEPTH;
        idx = -1;
        for (int k = 0; k < NUM_PE; k++)
            if (idx < 0 && bus.imp_valid[(m_ptr + k) % NUM_PE]) idx = (m_ptr + k) % NUM_PE;
        e_ir = (ok && !bus.dec_valid && idx >= 0) ? (1 << idx) : 0;
        chk("dec_ready", int'(bus.dec_ready), int'(ok));
        chk("imp_ready", int'(bus.imp_ready), e_ir);
        chk("lit_valid", int'(bus.lit_valid), int'(run0 && q.size() > 0));
        chk("lit_out", int'(bus.lit_out), q.size() > 0 ? q[0] : 0);
        chk("conflict", int'(bus.conflict), int'(m_conf));
        chk("quiescent", int'(bus.quiescent),
            int'(q.size() == 0 && !bus.dec_valid && bus.imp_valid == 0 && !m_conf));
        if (!rst_n || bus.clear) begin
            q.delete();
            foreach (asg[i]) asg[i] = 0;
            m_conf = 0;
            m_ptr = 0;
        end else begin
            if (run0 && q.size() > 0 && bus.lit_ready) void'(q.pop_front());
            acc = 0;
            l = 0;
            if (bus.dec_valid && ok) begin
                acc = 1;
                l = int'(bus.dec_lit);
            end else if (e_ir != 0) begin
                acc = 1;
                l = int'(bus.imp_lit[idx]);
                m_ptr = (idx + 1) % NUM_PE;
            end
            if (acc && l != 0 && l != -LIT_INDEX_MAX) begin
`ifdef BCP_IMPLY_DEDUP_EN
                v = l < 0 ? -l : l;
                s = l < 0 ? -1 : 1;
                if (asg[v] == 0) begin
                    asg[v] = s;
                    q.push_back(l);
                end else if (asg[v] != s) begin
                    m_conf = 1;
                end
`else
                v = 0;
                s = 0;
                q.push_back(l);
`endif
            end
            if (run0 && bus.pe_conflict != 0) m_conf = 1;
            if (m_conf) q.delete();
        end
    end

    initial begin
        bus.dec_valid = 0;
        bus.dec_lit = '0;
        bus.imp_valid = '0;
        foreach (bus.imp_lit[i]) bus.imp_lit[i] = '0;
        bus.pe_conflict = '0;
        bus.lit_ready = 0;
        bus.clear = 0;
        mid();
        chk("rst_dec_ready", int'(bus.dec_ready), 0);
        chk("rst_lit_out", int'(bus.lit_out), 0);
        chk("rst_quiescent", int'(bus.quiescent), 1);
        tick();
        rst_n = 1;
        tick();
        // Decision 5 out and back.
        bus.dec_valid = 1;
        bus.dec_lit = lit_t'(5);
        mid();
        chk("dec5_ready", int'(bus.dec_ready), 1);
        tick();
        bus.dec_valid = 0;
        bus.lit_ready = 1;
        mid();
        chk("dec5_valid", int'(bus.lit_valid), 1);
        chk("dec5_out", int'(bus.lit_out), 5);
        tick();
        bus.lit_ready = 0;
        mid();
        chk("dec5_quiescent", int'(bus.quiescent), 1);
        tick();
        // Round robin PE0 then PE2.
        bus.imp_valid = 4'b0101;
        bus.imp_lit[0] = lit_t'(-7);
        bus.imp_lit[2] = lit_t'(9);
        mid();
        chk("rr_pe0", int'(bus.imp_ready), 1);
        tick();
        bus.imp_valid = 4'b0100;
        mid();
        chk("rr_pe2", int'(bus.imp_ready), 4);
        chk("rr_out_m7", int'(bus.lit_out), -7);
        tick();
        bus.imp_valid = '0;
        bus.lit_ready = 1;
        tick();
        mid();
        chk("rr_out_9", int'(bus.lit_out), 9);
        tick();
        bus.lit_ready = 0;
        mid();
        chk("rr_empty", int'(bus.lit_valid), 0);
        tick();
        // Same literal again.
        bus.imp_valid = 4'b0010;
        bus.imp_lit[1] = lit_t'(9);
        mid();
        chk("dup_ready", int'(bus.imp_ready), 2);
        tick();
        bus.imp_valid = '0;
        bus.lit_ready = 1;
        mid();
`ifdef BCP_IMPLY_DEDUP_EN
        chk("dup_dropped", int'(bus.lit_valid), 0);
`else
        chk("dup_pushed", int'(bus.lit_out), 9);
`endif
        tick();
        bus.lit_ready = 0;
        // Reserved codes dropped, largest variable kept.
        bus.dec_valid = 1;
        bus.dec_lit = lit_t'(0);
        tick();
        bus.dec_lit = lit_t'(-1024);
        tick();
        bus.dec_lit = lit_t'(1023);
        tick();
        bus.dec_valid = 0;
        bus.lit_ready = 1;
        mid();
        chk("max_var_out", int'(bus.lit_out), 1023);
        tick();
        bus.lit_ready = 0;
        // Opposite polarity.
        bus.imp_valid = 4'b1000;
        bus.imp_lit[3] = lit_t'(-9);
        mid();
        chk("contra_ready", int'(bus.imp_ready), 8);
        tick();
        bus.imp_valid = 4'b1111;
        bus.dec_valid = 1;
        bus.dec_lit = lit_t'(3);
        mid();
`ifdef BCP_IMPLY_DEDUP_EN
        chk("contra_flag", int'(bus.conflict), 1);
        chk("contra_lit_valid", int'(bus.lit_valid), 0);
        chk("contra_dec_ready", int'(bus.dec_ready), 0);
        chk("contra_imp_ready", int'(bus.imp_ready), 0);
`else
        chk("contra_no_flag", int'(bus.conflict), 0);
        chk("contra_pushed", int'(bus.lit_out), -9);
`endif
        tick();
        tick();
        bus.imp_valid = '0;
        bus.dec_valid = 0;
        bus.clear = 1;
        tick();
        bus.clear = 0;
        mid();
        chk("clear_conflict", int'(bus.conflict), 0);
        tick();
        // Fill to depth with no consumer.
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            bus.dec_valid = 1;
            bus.dec_lit = lit_t'(i);
            tick();
        end
        bus.dec_lit = lit_t'(17);
        mid();
        chk("full_dec_ready", int'(bus.dec_ready), 0);
        tick();
        bus.dec_valid = 0;
        bus.imp_valid = 4'b0001;
        bus.imp_lit[0] = lit_t'(20);
        mid();
        chk("full_imp_ready", int'(bus.imp_ready), 0);
        tick();
        bus.lit_ready = 1;
        mid();
        chk("full_pop_cycle_ready", int'(bus.imp_ready), 0);
        tick();
        bus.lit_ready = 0;
        mid();
        chk("after_pop_ready", int'(bus.imp_ready), 1);
        tick();
        bus.imp_valid = '0;
        mid();
        chk("refull_dec_ready", int'(bus.dec_ready), 0);
        tick();
        bus.lit_ready = 1;
        repeat (FIFO_DEPTH) tick();
        bus.lit_ready = 0;
        mid();
        chk("drained", int'(bus.lit_valid), 0);
        tick();
        // Clear beats a same-cycle PE conflict and wipes the table.
        bus.pe_conflict = 4'b1000;
        bus.clear = 1;
        tick();
        bus.pe_conflict = '0;
        bus.clear = 0;
        bus.imp_valid = 4'b0010;
        bus.imp_lit[1] = lit_t'(-9);
        mid();
        chk("clear_wins", int'(bus.conflict), 0);
        chk("after_clear_ready", int'(bus.imp_ready), 2);
        tick();
        bus.imp_valid = '0;
        mid();
        chk("after_clear_conflict", int'(bus.conflict), 0);
        chk("after_clear_out", int'(bus.lit_out), -9);
        tick();
        // PE conflict alone.
        bus.pe_conflict = 4'b0001;
        tick();
        bus.pe_conflict = '0;
        mid();
        chk("pe_conflict_flag", int'(bus.conflict), 1);
        chk("pe_conflict_flush", int'(bus.lit_valid), 0);
        tick();
        bus.clear = 1;
        tick();
        bus.clear = 0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
